// File: rtl/fractal_dispatcher.sv
// Raster-order pixel scheduler for the fractal core array: hands start coordinates
// to idle cores in the selected subset and streams finished iteration counts out.

module fractal_dispatch_lane #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 22
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  load,
  input  logic                  done,
  input  logic [DATA_WIDTH-1:0] x_in,
  input  logic [DATA_WIDTH-1:0] y_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  output logic                  busy,
  output logic                  pending,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] x0,
  output logic [DATA_WIDTH-1:0] y0
);
  logic                  fresh;
  logic [DATA_WIDTH-1:0] x_q, y_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      pending <= 1'b0;
      fresh   <= 1'b0;
      addr    <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      fresh <= start;
      if (start) begin
        busy <= 1'b1;
        addr <= addr_in;
        x_q  <= x_in;
        y_q  <= y_in;
      end else if (load) begin
        busy <= 1'b0;
      end
      // fresh hides the previous pixel's done level still held by the core
      pending <= (pending | (done & busy & ~fresh)) & ~load & ~start;
    end
  end

  assign x0 = start ? x_in : x_q;
  assign y0 = start ? y_in : y_q;
endmodule

module fractal_dispatcher #(
  parameter int INTEGER_BITS      = 8,
  parameter int FRACTIONAL_BITS   = 24,
  parameter int MAX_ITER_WIDTH    = 16,
  parameter int MANDEL_CORE_COUNT = 8,
  parameter int JULIA_CORE_COUNT  = 8,
  parameter int DIM_WIDTH         = 11,
  parameter int ADDR_WIDTH        = 22,
  localparam int DATA_WIDTH = INTEGER_BITS + FRACTIONAL_BITS,
  localparam int CORE_COUNT = MANDEL_CORE_COUNT + JULIA_CORE_COUNT
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 frame_start_i,
  input  logic                                 mode_i,
  input  logic [DIM_WIDTH-1:0]                 width_i,
  input  logic [DIM_WIDTH-1:0]                 height_i,
  input  logic [DATA_WIDTH-1:0]                x_start_i,
  input  logic [DATA_WIDTH-1:0]                y_start_i,
  input  logic [DATA_WIDTH-1:0]                step_i,
  output logic [CORE_COUNT-1:0]                start_o,
  output logic [DATA_WIDTH*CORE_COUNT-1:0]     x0_o,
  output logic [DATA_WIDTH*CORE_COUNT-1:0]     y0_o,
  input  logic [MAX_ITER_WIDTH*CORE_COUNT-1:0] iter_i,
  input  logic [CORE_COUNT-1:0]                done_i,
  output logic                                 res_valid_o,
  input  logic                                 res_ready_i,
  output logic [ADDR_WIDTH-1:0]                res_addr_o,
  output logic [MAX_ITER_WIDTH-1:0]            res_iter_o,
  output logic                                 busy_o,
  output logic                                 frame_done_o
);
  localparam int IDX_W = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;
  localparam logic [DIM_WIDTH-1:0]  DIM_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic                  mode_q;
  logic [DIM_WIDTH-1:0]  width_q, height_q, col, row;
  logic [DATA_WIDTH-1:0] x_start_q, step_q, x_cur, y_cur;
  logic [ADDR_WIDTH-1:0] pix_addr;
  logic                  res_valid;
  logic [ADDR_WIDTH-1:0] res_addr;
  logic [MAX_ITER_WIDTH-1:0] res_iter;

  logic [CORE_COUNT-1:0] elig, busy_vec, pend_vec, start_vec, load_vec;
  logic [CORE_COUNT-1:0][ADDR_WIDTH-1:0]     lane_addr;
  logic [CORE_COUNT-1:0][MAX_ITER_WIDTH-1:0] iter_arr;
  logic [IDX_W-1:0] target, sel;
  logic             found, pend_any, dispatch, load_en, last_pix;

  assign iter_arr = iter_i;

  // lowest-index idle eligible core takes the next pixel
  always_comb begin
    found  = 1'b0;
    target = '0;
    for (int k = 0; k < CORE_COUNT; k++) begin
      if (!found && elig[k] && !busy_vec[k]) begin
        found  = 1'b1;
        target = IDX_W'(k);
      end
    end
  end

  always_comb begin
    pend_any = 1'b0;
    sel      = '0;
    for (int k = 0; k < CORE_COUNT; k++) begin
      if (!pend_any && pend_vec[k]) begin
        pend_any = 1'b1;
        sel      = IDX_W'(k);
      end
    end
  end

  assign dispatch = (state == DISPATCH) && found;
  assign load_en  = pend_any && (!res_valid || res_ready_i);
  assign last_pix = (col == width_q - DIM_ONE) && (row == height_q - DIM_ONE);

  genvar g;
  generate
    for (g = 0; g < CORE_COUNT; g++) begin : g_lane
      assign elig[g]      = (g < MANDEL_CORE_COUNT) ? ~mode_q : mode_q;
      assign start_vec[g] = dispatch && (target == IDX_W'(g));
      assign load_vec[g]  = load_en && (sel == IDX_W'(g));

      fractal_dispatch_lane #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
      ) u_lane (
        .clk     (clk_i),
        .rst     (rst_i),
        .start   (start_vec[g]),
        .load    (load_vec[g]),
        .done    (done_i[g]),
        .x_in    (x_cur),
        .y_in    (y_cur),
        .addr_in (pix_addr),
        .busy    (busy_vec[g]),
        .pending (pend_vec[g]),
        .addr    (lane_addr[g]),
        .x0      (x0_o[(g+1)*DATA_WIDTH-1 -: DATA_WIDTH]),
        .y0      (y0_o[(g+1)*DATA_WIDTH-1 -: DATA_WIDTH])
      );
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (frame_start_i)
                  state_nxt = (width_i == '0 || height_i == '0) ? DONE : DISPATCH;
      DISPATCH: if (dispatch && last_pix) state_nxt = DRAIN;
      DRAIN:    if (busy_vec == '0 && pend_vec == '0 && !res_valid) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q    <= 1'b0;
      width_q   <= '0;
      height_q  <= '0;
      x_start_q <= '0;
      step_q    <= '0;
      col       <= '0;
      row       <= '0;
      x_cur     <= '0;
      y_cur     <= '0;
      pix_addr  <= '0;
      res_valid <= 1'b0;
      res_addr  <= '0;
      res_iter  <= '0;
    end else begin
      if (state == IDLE && frame_start_i) begin
        mode_q    <= mode_i;
        width_q   <= width_i;
        height_q  <= height_i;
        x_start_q <= x_start_i;
        step_q    <= step_i;
        col       <= '0;
        row       <= '0;
        x_cur     <= x_start_i;
        y_cur     <= y_start_i;
        pix_addr  <= '0;
      end else if (dispatch) begin
        pix_addr <= pix_addr + ADDR_ONE;
        if (col == width_q - DIM_ONE) begin
          col   <= '0;
          row   <= row + DIM_ONE;
          x_cur <= x_start_q;
          y_cur <= y_cur + step_q;
        end else begin
          col   <= col + DIM_ONE;
          x_cur <= x_cur + step_q;
        end
      end
      if (load_en) begin
        res_valid <= 1'b1;
        res_addr  <= lane_addr[sel];
        res_iter  <= iter_arr[sel];
      end else if (res_ready_i) begin
        res_valid <= 1'b0;
      end
    end
  end

  assign start_o      = start_vec;
  assign res_valid_o  = res_valid;
  assign res_addr_o   = res_addr;
  assign res_iter_o   = res_iter;
  assign busy_o       = (state != IDLE);
  assign frame_done_o = (state == DONE);
endmodule

// File: tb/tb_fractal_dispatcher.sv
// Directed bench: behavioural cores with programmable latency feed the dispatcher;
// a scoreboard of expected (addr, iter) pairs is consumed as results stream out.
module tb_fractal_dispatcher;
  localparam int C  = 16;
  localparam int DW = 32;
  localparam int IW = 16;

  logic            clk = 1'b0;
  logic            rst, frame_start, mode, res_ready;
  logic [10:0]     width, height;
  logic [DW-1:0]   x_start, y_start, step;
  logic [C-1:0]    start, done;
  logic [DW*C-1:0] x0, y0;
  logic [IW*C-1:0] iter_bus;
  logic            res_valid, busy, frame_done;
  logic [21:0]     res_addr;
  logic [IW-1:0]   res_iter;

  fractal_dispatcher dut (
    .clk_i(clk), .rst_i(rst), .frame_start_i(frame_start), .mode_i(mode),
    .width_i(width), .height_i(height), .x_start_i(x_start), .y_start_i(y_start),
    .step_i(step), .start_o(start), .x0_o(x0), .y0_o(y0), .iter_i(iter_bus),
    .done_i(done), .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_addr_o(res_addr), .res_iter_o(res_iter), .busy_o(busy),
    .frame_done_o(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; logic [IW-1:0] iter; } exp_t;
  exp_t sb[$];
  int   start_log[$];

  int vectors = 0, errs = 0;
  int n_starts, n_results, n_fd, n_busy, bad, tot_st, tot_hs;
  int lat_mode = 0;
  logic          cur_mode = 1'b0;
  logic          hold = 1'b0;
  logic [21:0]   h_addr;
  logic [IW-1:0] h_iter;

  function automatic logic [IW-1:0] hash(input logic [DW-1:0] x, input logic [DW-1:0] y);
    return x[31:16] ^ y[23:8] ^ 16'h5a5a;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // behavioural cores: done rises a few cycles after start and holds until the next start
  int            cnt [C];
  logic [DW-1:0] xl [C], yl [C];
  logic [IW-1:0] it [C];

  always @(posedge clk) begin
    for (int k = 0; k < C; k++) begin
      if (rst) begin
        cnt[k] <= 0; done[k] <= 1'b0; it[k] <= '0; xl[k] <= '0; yl[k] <= '0;
      end else if (start[k]) begin
        cnt[k]  <= (lat_mode == 1) ? 30 : int'($urandom_range(40, 1));
        done[k] <= 1'b0;
        xl[k]   <= x0[k*DW +: DW];
        yl[k]   <= y0[k*DW +: DW];
      end else if (cnt[k] > 0) begin
        cnt[k] <= cnt[k] - 1;
        if (cnt[k] == 1) begin
          done[k] <= 1'b1;
          it[k]   <= hash(xl[k], yl[k]);
        end
      end
    end
  end

  always_comb begin
    iter_bus = '0;
    for (int k = 0; k < C; k++) iter_bus[k*IW +: IW] = it[k];
  end

  always @(negedge clk) begin
    if (rst) begin
      tot_st = 0; tot_hs = 0; hold = 1'b0;
    end else begin
      logic [C-1:0] elig;
      int idx;
      elig = cur_mode ? 16'hFF00 : 16'h00FF;
      if (busy) n_busy++;
      if (frame_done) n_fd++;
      if ($countones(start) > 1) bad++;
      if ((start & ~elig) != '0) bad++;
      for (int k = 0; k < C; k++) if (start[k]) start_log.push_back(k);
      n_starts += $countones(start);
      tot_st   += $countones(start);
      if (hold && !(res_valid && res_addr == h_addr && res_iter == h_iter)) bad++;
      if (res_valid && res_ready) begin
        n_results++; tot_hs++;
        idx = -1;
        for (int i = 0; i < sb.size(); i++) if (sb[i].addr == int'(res_addr)) idx = i;
        check("res_addr_known", 64'(idx >= 0), 64'd1);
        if (idx >= 0) begin
          check("res_iter", 64'(res_iter), 64'(sb[idx].iter));
          sb.delete(idx);
        end
      end
      if (tot_st - tot_hs > 9) bad++;
      hold   = res_valid && !res_ready;
      h_addr = res_addr;
      h_iter = res_iter;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic setup_frame(input logic m, input int w, input int h,
                             input logic [DW-1:0] xs, input logic [DW-1:0] ys,
                             input logic [DW-1:0] st);
    exp_t e;
    n_starts = 0; n_results = 0; n_fd = 0; n_busy = 0; bad = 0;
    start_log.delete();
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        e.addr = r * w + c;
        e.iter = hash(xs + st * DW'(c), ys + st * DW'(r));
        sb.push_back(e);
      end
    cur_mode = m; mode = m;
    width = 11'(w); height = 11'(h);
    x_start = xs; y_start = ys; step = st;
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int c = 0;
    while (n_fd == 0 && c < 20000) begin tick(1); c++; end
    check(tag, 64'(n_fd > 0), 64'd1);
    tick(3);
  endtask

  int s60, o60;

  initial begin
    rst = 1'b1; frame_start = 1'b0; mode = 1'b0; res_ready = 1'b1;
    width = '0; height = '0; x_start = '0; y_start = '0; step = '0;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_start", 64'(start), 64'd0);
    check("rst_valid", 64'(res_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_fdone", 64'(frame_done), 64'd0);
    check("rst_x0_any", 64'(|x0), 64'd0);
    check("rst_addr", 64'(res_addr), 64'd0);

    // mode 0, 4x2 at (-2.0, 1.0) step 0.5
    setup_frame(1'b0, 4, 2, 32'hFE000000, 32'h01000000, 32'h00800000);
    wait_done("a_frame_done");
    check("a_starts", 64'(n_starts), 64'd8);
    for (int i = 0; i < 8; i++) check("a_start_order", 64'(start_log[i]), 64'(i));
    check("a_core3_x0", 64'(xl[3]), 64'hFF800000);
    check("a_core3_y0", 64'(yl[3]), 64'h01000000);
    check("a_core4_x0", 64'(xl[4]), 64'hFE000000);
    check("a_core4_y0", 64'(yl[4]), 64'h01800000);
    check("a_x0_hold3", 64'(x0[127:96]), 64'hFF800000);
    check("a_results", 64'(n_results), 64'd8);
    check("a_sb_empty", 64'(sb.size()), 64'd0);
    check("a_fd_once", 64'(n_fd), 64'd1);
    check("a_bad", 64'(bad), 64'd0);

    // mode 1, 16x16, random latency
    setup_frame(1'b1, 16, 16, 32'hFF000000, 32'hFF400000, 32'h00040000);
    wait_done("b_frame_done");
    check("b_starts", 64'(n_starts), 64'd256);
    check("b_results", 64'(n_results), 64'd256);
    check("b_sb_empty", 64'(sb.size()), 64'd0);
    check("b_bad", 64'(bad), 64'd0);

    // backpressure mid-frame
    setup_frame(1'b0, 8, 8, 32'h00100000, 32'hFFF00000, 32'h00123456);
    tick(20);
    res_ready = 1'b0;
    tick(60);
    s60 = n_starts;
    o60 = tot_st - tot_hs;
    check("c_hold_valid", 64'(res_valid), 64'd1);
    check("c_outstanding", 64'(o60), 64'd9);
    tick(40);
    check("c_no_starts", 64'(n_starts - s60), 64'd0);
    res_ready = 1'b1;
    wait_done("c_frame_done");
    check("c_results", 64'(n_results), 64'd64);
    check("c_sb_empty", 64'(sb.size()), 64'd0);
    check("c_bad", 64'(bad), 64'd0);

    // zero-width frame
    setup_frame(1'b0, 0, 5, 32'h0, 32'h0, 32'h00010000);
    wait_done("d_frame_done");
    check("d_busy_cycles", 64'(n_busy), 64'd1);
    check("d_fd_once", 64'(n_fd), 64'd1);
    check("d_starts", 64'(n_starts), 64'd0);

    // reset during drain, then a clean frame
    lat_mode = 1;
    setup_frame(1'b0, 2, 2, 32'h01000000, 32'h02000000, 32'h00200000);
    tick(10);
    check("e_starts", 64'(n_starts), 64'd4);
    check("e_busy_drain", 64'(busy), 64'd1);
    rst = 1'b1;
    tick(1);
    check("e_rst_start", 64'(start), 64'd0);
    check("e_rst_x0", 64'(|x0), 64'd0);
    check("e_rst_y0", 64'(|y0), 64'd0);
    check("e_rst_valid", 64'(res_valid), 64'd0);
    check("e_rst_addr", 64'(res_addr), 64'd0);
    check("e_rst_iter", 64'(res_iter), 64'd0);
    check("e_rst_busy", 64'(busy), 64'd0);
    check("e_rst_fdone", 64'(frame_done), 64'd0);
    rst = 1'b0;
    sb.delete();
    lat_mode = 0;
    tick(1);
    setup_frame(1'b1, 3, 3, 32'hFFC00000, 32'h00400000, 32'h00300000);
    wait_done("e_frame_done");
    check("e_results", 64'(n_results), 64'd9);
    check("e_sb_empty", 64'(sb.size()), 64'd0);
    check("e_bad", 64'(bad), 64'd0);

    // frame_start during dispatch is ignored
    setup_frame(1'b1, 5, 3, 32'h00000000, 32'h00000000, 32'h00010000);
    tick(2);
    width = 11'd7;
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    wait_done("f_frame_done");
    check("f_results", 64'(n_results), 64'd15);
    check("f_sb_empty", 64'(sb.size()), 64'd0);
    check("f_fd_once", 64'(n_fd), 64'd1);
    tick(5);
    check("f_idle_after", 64'(busy), 64'd0);
    check("f_bad", 64'(bad), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
